// File: rtl/spi_lcd_sink.sv
// spi_lcd_sink: SPI mode-0 target receiver for the LCD command/data link.
// Oversamples the asynchronous SPI pins, assembles MSB-first bytes tagged with
// lcd_dc, and queues them in a small show-ahead FIFO read via valid/ready.
module spi_lcd_sink #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    input  logic        lcd_dc,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [7:0]  rd_data,
    output logic        rd_dc,
    output logic [15:0] byte_count,
    output logic        overflow,
    output logic        frame_err,
    input  logic        clear_flags
);

    localparam int            AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW         = AW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [7:0]    SETTLE_MAX = 8'(SYNC_STAGES);
    // Per-stage reset pattern {dc, cs_n, mosi, sclk}: chip select idles high.
    localparam logic [3:0]    SYNC_RST   = 4'b0100;

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers; index 0 takes the pins, the last index is used.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic sclk_s, mosi_s, cs_s, dc_s;
    logic sclk_prev_q, sclk_prev_d;
    logic sclk_rise;

    // Shift every pin one stage deeper into its synchronizer chain.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], {lcd_dc, spi_cs_n, spi_mosi, spi_clk}};
        sclk_prev_d = sclk_s;
    end

    assign sclk_s    = sync_q[SYNC_STAGES-1][0];
    assign mosi_s    = sync_q[SYNC_STAGES-1][1];
    assign cs_s      = sync_q[SYNC_STAGES-1][2];
    assign dc_s      = sync_q[SYNC_STAGES-1][3];
    assign sclk_rise = sclk_s & ~sclk_prev_q;

    // Synchronizer chain and edge-detect history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= {SYNC_STAGES{SYNC_RST}};
            sclk_prev_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            sclk_prev_q <= sclk_prev_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine and byte assembly
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  settle_q, settle_d;
    logic        armed_q, armed_d;
    logic        push_req;
    logic [8:0]  push_entry;
    logic        frame_set;

    // Next-state for frame tracking. After reset the synchronizer still holds
    // its reset value, so "cs_n seen high" only counts once the chain has been
    // refilled from the pin (settle); this stops capture resuming mid-frame.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        settle_d   = settle_q;
        armed_d    = armed_q;
        push_req   = 1'b0;
        frame_set  = 1'b0;
        push_entry = {dc_s, shift_q[6:0], mosi_s};
        if (settle_q != SETTLE_MAX) begin
            settle_d = settle_q + 8'd1;
        end
        case (state_q)
            S_IDLE: begin
                if ((settle_q == SETTLE_MAX) && cs_s) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !cs_s) begin
                    state_d   = S_ACTIVE;
                    bit_cnt_d = 3'd0;
                end
            end
            S_ACTIVE: begin
                if (cs_s) begin
                    // Deselect wins over a coincident clock edge.
                    state_d   = S_IDLE;
                    bit_cnt_d = 3'd0;
                    if (bit_cnt_q != 3'd0) begin
                        frame_set = 1'b1;
                    end
                end else if (sclk_rise) begin
                    shift_d   = {shift_q[6:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        push_req = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO, counters and sticky flags
    // ------------------------------------------------------------------
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count_q, count_d;
    logic [8:0]    head_q, head_d;
    logic [15:0]   byte_count_q, byte_count_d;
    logic          overflow_q, overflow_d;
    logic          frame_err_q, frame_err_d;
    logic          pop, full, accept, drop;

    assign rd_valid   = (count_q != '0);
    assign rd_data    = head_q[7:0];
    assign rd_dc      = head_q[8];
    assign byte_count = byte_count_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;

    // FIFO bookkeeping; a pop frees the slot a full-FIFO push needs.
    always_comb begin
        pop          = rd_valid && rd_ready;
        full         = (count_q == DEPTH_C);
        accept       = push_req && (!full || pop);
        drop         = push_req && full && !pop;
        rd_ptr_nxt   = rd_ptr_q + AW'(1);
        wr_ptr_d     = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_nxt : rd_ptr_q;
        count_d      = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Head register: the incoming byte becomes head when it lands in an
        // empty (or emptying) FIFO, otherwise the next stored entry moves up.
        head_d = head_q;
        if (accept && ((count_q == '0) || ((count_q == CW'(1)) && pop))) begin
            head_d = push_entry;
        end else if (pop && (count_q > CW'(1))) begin
            head_d = mem[rd_ptr_nxt];
        end
        byte_count_d = accept ? byte_count_q + 16'd1 : byte_count_q;
        // Set has priority over clear on the sticky flags.
        overflow_d   = drop ? 1'b1 : (clear_flags ? 1'b0 : overflow_q);
        frame_err_d  = frame_set ? 1'b1 : (clear_flags ? 1'b0 : frame_err_q);
    end

    // FIFO storage has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= push_entry;
        end
    end

    // State machine, FIFO pointers, head register, counter and flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            settle_q     <= 8'd0;
            armed_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= 9'd0;
            byte_count_q <= 16'd0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            settle_q     <= settle_d;
            armed_q      <= armed_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            byte_count_q <= byte_count_d;
            overflow_q   <= overflow_d;
            frame_err_q  <= frame_err_d;
        end
    end

endmodule
